dma_stream_engine: RTL and testbench

Parametrised successor to the fixed five-port DMA bank array. For each of NUM_CH channels it captures words from the PE array into a ping-pong pair of SRAM banks and streams completed banks back out, with valid/ready flow control on both sides. Per-channel run-time configuration sets the transfer length and the mode: one-shot pass-through, or loop replay of a captured bank. Sits between the PE array ports and the on-chip memory banks.

---
 rtl/dma_pkg.sv | 41 ++++
 rtl/dma_stream_chan.sv | 215 +++++++++++++++++++++
 rtl/dma_stream_engine.sv | 55 +++++
 tb/tb_dma_stream_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the multi-channel ping-pong DMA stream engine.
package dma_pkg;

    localparam int CFG_LEN_W = 17;

    typedef enum logic {
        PASS = 1'b0,
        LOOP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_FILL,
        F_WAIT
    } fill_state_e;

    typedef enum logic {
        D_IDLE,
        D_DRAIN
    } drain_state_e;

    typedef enum logic {
        EMPTY,
        FULL
    } bank_state_e;

    typedef struct packed {
        logic                 en;
        mode_e                mode;
        logic [CFG_LEN_W-1:0] len;
    } cfg_t;

    // A bank holds 1..2**aw words.
    function automatic logic len_legal(
        input logic [CFG_LEN_W-1:0] len,
        input int unsigned          aw
    );
        return (len != '0) && (len <= (CFG_LEN_W'(1) << aw));
    endfunction

endpackage

// File: rtl/dma_stream_chan.sv
// One DMA channel: capture into a ping-pong bank pair, stream completed
// banks out through a 2-entry buffer that absorbs the in-flight read.
module dma_stream_chan
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid_i,
    input  cfg_t                  cfg_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic                  active_o,
    output logic                  cfg_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef logic [CW-1:0] cnt_t;

    logic                  active_q, active_d;
    mode_e                 mode_q, mode_d;
    cnt_t                  len_q, len_d;
    logic                  err_q, err_d;

    fill_state_e           fst_q, fst_d;
    logic                  fill_sel_q, fill_sel_d;
    cnt_t                  fill_addr_q, fill_addr_d;

    drain_state_e          dst_q, dst_d;
    logic                  drain_sel_q, drain_sel_d;
    cnt_t                  rd_addr_q, rd_addr_d;

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];

    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];
    logic                  head_q, head_d;
    logic [1:0]            cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

    logic                  cfg_ok;
    cnt_t                  len_m1;
    logic                  loop_full;
    logic                  wr_go;
    logic                  wr_last;
    logic                  pop;
    logic [2:0]            occ;
    logic                  rd_go;
    logic                  rd_last;
    logic                  rel;
    logic                  other_free;

    assign cfg_ok     = len_legal(cfg_i.len, ADDR_WIDTH);
    assign len_m1     = len_q - cnt_t'(1);
    assign loop_full  = (mode_q == LOOP) &&
                        ((bank_q[0] == FULL) || (bank_q[1] == FULL));

    assign in_ready_o = active_q && (fst_q == F_FILL) && !loop_full;
    assign wr_go      = in_valid_i && in_ready_o;
    assign wr_last    = fill_addr_q == len_m1;

    assign out_valid_o = cnt_q != 2'd0;
    assign out_data_o  = obuf_q[head_q];
    assign pop         = out_valid_o && out_ready_i;

    // Buffer occupancy counts the read already in flight.
    assign occ     = 3'(cnt_q) + 3'(rd_pend_q);
    assign rd_go   = active_q && (bank_q[drain_sel_q] == FULL) &&
                     ((occ < 3'd2) || pop);
    assign rd_last = rd_addr_q == len_m1;
    assign rel     = rd_go && rd_last && (mode_q == PASS);

    assign other_free = (bank_q[~fill_sel_q] == EMPTY) ||
                        (rel && (drain_sel_q != fill_sel_q));

    assign active_o  = active_q;
    assign cfg_err_o = err_q;

    always_comb begin
        active_d    = active_q;
        mode_d      = mode_q;
        len_d       = len_q;
        err_d       = err_q;
        fst_d       = fst_q;
        fill_sel_d  = fill_sel_q;
        fill_addr_d = fill_addr_q;
        dst_d       = dst_q;
        drain_sel_d = drain_sel_q;
        rd_addr_d   = rd_addr_q;
        bank_d      = bank_q;
        rd_pend_d   = rd_go;
        obuf_d      = obuf_q;
        head_d      = head_q;
        cnt_d       = cnt_q + 2'(rd_pend_q) - 2'(pop);

        if (wr_go) begin
            fill_addr_d = fill_addr_q + cnt_t'(1);
            if (wr_last) begin
                bank_d[fill_sel_q] = FULL;
                fill_addr_d        = '0;
                if (other_free) begin
                    fill_sel_d = ~fill_sel_q;
                end else begin
                    fst_d = F_WAIT;
                end
            end
        end

        if ((fst_q == F_WAIT) && rel) begin
            fill_sel_d = ~fill_sel_q;
            fst_d      = F_FILL;
        end

        if (rd_go) begin
            rd_addr_d = rd_addr_q + cnt_t'(1);
            dst_d     = D_DRAIN;
            if (rd_last) begin
                rd_addr_d = '0;
                if (mode_q == PASS) begin
                    bank_d[drain_sel_q] = EMPTY;
                    drain_sel_d         = ~drain_sel_q;
                    dst_d               = D_IDLE;
                end
            end
        end

        if (rd_pend_q) begin
            obuf_d[head_q ^ cnt_q[0]] = rdata_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end

        // A bad length leaves the running transfer untouched.
        if (cfg_valid_i) begin
            if (cfg_i.en && !cfg_ok) begin
                err_d = 1'b1;
            end else begin
                err_d       = 1'b0;
                active_d    = cfg_i.en;
                mode_d      = cfg_i.mode;
                len_d       = cfg_i.len[ADDR_WIDTH:0];
                fst_d       = cfg_i.en ? F_FILL : F_IDLE;
                fill_sel_d  = 1'b0;
                fill_addr_d = '0;
                dst_d       = D_IDLE;
                drain_sel_d = 1'b0;
                rd_addr_d   = '0;
                bank_d      = '{EMPTY, EMPTY};
                rd_pend_d   = 1'b0;
                head_d      = 1'b0;
                cnt_d       = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= 1'b0;
            mode_q      <= PASS;
            len_q       <= cnt_t'(1);
            err_q       <= 1'b0;
            fst_q       <= F_IDLE;
            fill_sel_q  <= 1'b0;
            fill_addr_q <= '0;
            dst_q       <= D_IDLE;
            drain_sel_q <= 1'b0;
            rd_addr_q   <= '0;
            bank_q      <= '{EMPTY, EMPTY};
            rd_pend_q   <= 1'b0;
            obuf_q      <= '{'0, '0};
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            active_q    <= active_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            err_q       <= err_d;
            fst_q       <= fst_d;
            fill_sel_q  <= fill_sel_d;
            fill_addr_q <= fill_addr_d;
            dst_q       <= dst_d;
            drain_sel_q <= drain_sel_d;
            rd_addr_q   <= rd_addr_d;
            bank_q      <= bank_d;
            rd_pend_q   <= rd_pend_d;
            obuf_q      <= obuf_d;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
        end
    end

    // Bank storage: inferred RAM, one write and one registered read.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_q[fill_sel_q][fill_addr_q[ADDR_WIDTH-1:0]] <= in_data_i;
        end
        if (rd_go) begin
            rdata_q <= mem_q[drain_sel_q][rd_addr_q[ADDR_WIDTH-1:0]];
        end
    end

endmodule

// File: rtl/dma_stream_engine.sv
// NUM_CH-channel DMA stream engine between PE array ports and SRAM banks.
module dma_stream_engine
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_CH     = 5,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_valid,
    input  logic [CH_W-1:0]                    cfg_ch,
    input  logic                               cfg_en,
    input  logic                               cfg_mode,
    input  logic [ADDR_WIDTH:0]                cfg_len,
    input  logic [NUM_CH-1:0]                  in_valid,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0]                  in_ready,
    output logic [NUM_CH-1:0]                  out_valid,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]  out_data,
    input  logic [NUM_CH-1:0]                  out_ready,
    output logic [NUM_CH-1:0]                  ch_active,
    output logic [NUM_CH-1:0]                  cfg_err
);

    cfg_t cfg_w;

    assign cfg_w = '{
        en:   cfg_en,
        mode: mode_e'(cfg_mode),
        len:  CFG_LEN_W'(cfg_len)
    };

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dma_stream_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cfg_valid_i (cfg_valid && (cfg_ch == CH_W'(c))),
            .cfg_i       (cfg_w),
            .in_valid_i  (in_valid[c]),
            .in_data_i   (in_data[c]),
            .in_ready_o  (in_ready[c]),
            .out_valid_o (out_valid[c]),
            .out_data_o  (out_data[c]),
            .out_ready_i (out_ready[c]),
            .active_o    (ch_active[c]),
            .cfg_err_o   (cfg_err[c])
        );
    end

endmodule

// File: tb/tb_dma_stream_engine.sv
// Directed self-checking bench for dma_stream_engine.
module tb_dma_stream_engine;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic [2:0]       cfg_ch;
    logic             cfg_en;
    logic             cfg_mode;
    logic [9:0]       cfg_len;
    logic [4:0]       in_valid;
    logic [4:0][31:0] in_data;
    logic [4:0]       in_ready;
    logic [4:0]       out_valid;
    logic [4:0][31:0] out_data;
    logic [4:0]       out_ready;
    logic [4:0]       ch_active;
    logic [4:0]       cfg_err;

    int          total = 0;
    int          bad   = 0;
    int          wi, ro, guard;
    logic        prev_stall, acc_in;
    logic [31:0] prev_data;
    int          seq [3];

    dma_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_mode  (cfg_mode),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ch_active (ch_active),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic en, input logic mode,
                       input int len);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_en    = en;
        cfg_mode  = mode;
        cfg_len   = 10'(len);
        tick;
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_en    = 1'b0;
        cfg_mode  = 1'b0;
        cfg_len   = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        seq       = '{7, 8, 9};

        // reset state
        tick;
        tick;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(|out_data), 0);
        check("rst_active", 32'(ch_active), 0);
        check("rst_err", 32'(cfg_err), 0);
        rst = 1'b0;
        tick;
        check("idle_in_ready", 32'(in_ready), 0);
        check("idle_out_valid", 32'(out_valid), 0);

        // ch0 len=4 PASS, 8 words back-to-back
        cfg(0, 1'b1, 1'b0, 4);
        check("cfg_in_ready", 32'(in_ready), 32'h1);
        check("cfg_active", 32'(ch_active), 32'h1);
        for (int n = 1; n <= 15; n++) begin
            in_valid[0] = (n <= 8);
            in_data[0]  = 32'(n);
            if (n <= 8) check("pass_no_bubble", 32'(in_ready[0]), 1);
            tick;
            check("pass_valid", 32'(out_valid[0]),
                  32'((n >= 6) && (n <= 13)));
            if (n >= 6 && n <= 13) check("pass_data", out_data[0], 32'(n - 5));
        end
        in_valid[0] = 1'b0;

        // out_ready toggling, 12 words: third bank must wait
        cfg(0, 1'b1, 1'b0, 4);
        wi = 0;
        ro = 0;
        guard = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (ro < 12 && guard < 200) begin
            guard++;
            out_ready[0] = guard[0];
            in_valid[0]  = (wi < 12);
            in_data[0]   = 32'(wi + 1);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid[0]), 1);
                check("stall_data", out_data[0], prev_data);
            end
            acc_in = in_valid[0] && in_ready[0];
            if (out_valid[0] && out_ready[0]) begin
                check("stall_seq", out_data[0], 32'(ro + 1));
                ro++;
            end
            prev_stall = out_valid[0] && !out_ready[0];
            prev_data  = out_data[0];
            tick;
            if (acc_in) begin
                wi++;
                if (wi == 8) check("f_wait_ready", 32'(in_ready[0]), 0);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        check("stall_count", 32'(ro), 12);
        check("stall_in_count", 32'(wi), 12);

        // ch2 len=3 LOOP replay
        cfg(2, 1'b1, 1'b1, 3);
        for (int n = 1; n <= 14; n++) begin
            in_valid[2] = (n <= 3);
            in_data[2]  = (n <= 3) ? 32'(seq[n-1]) : 32'h0;
            tick;
            if (n == 3) check("loop_ready_low", 32'(in_ready[2]), 0);
            if (n >= 5) begin
                check("loop_valid", 32'(out_valid[2]), 1);
                check("loop_data", out_data[2], 32'(seq[(n-5)%3]));
            end
        end
        in_valid[2] = 1'b0;

        // illegal lengths keep the channel running
        cfg(2, 1'b1, 1'b0, 0);
        check("err_len0", 32'(cfg_err[2]), 1);
        check("err_len0_active", 32'(ch_active[2]), 1);
        check("err_len0_valid", 32'(out_valid[2]), 1);
        cfg(2, 1'b1, 1'b0, 513);
        check("err_len513", 32'(cfg_err[2]), 1);
        check("err_len513_ready", 32'(in_ready[2]), 0);
        check("err_len513_valid", 32'(out_valid[2]), 1);
        cfg(2, 1'b0, 1'b0, 1);
        check("err_clear", 32'(cfg_err[2]), 0);
        check("dis_active", 32'(ch_active[2]), 0);
        check("dis_valid", 32'(out_valid[2]), 0);
        tick;
        tick;
        check("dis_valid_later", 32'(out_valid[2]), 0);

        // reconfig ch0 mid-drain
        out_ready[0] = 1'b0;
        cfg(0, 1'b1, 1'b0, 4);
        for (int n = 1; n <= 4; n++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'h10 + 32'(n);
            tick;
        end
        in_valid[0] = 1'b0;
        tick;
        tick;
        check("pre_abort_valid", 32'(out_valid[0]), 1);
        check("pre_abort_data", out_data[0], 32'h11);
        cfg(0, 1'b1, 1'b0, 2);
        check("abort_valid", 32'(out_valid[0]), 0);
        check("abort_ready", 32'(in_ready[0]), 1);
        for (int n = 0; n < 3; n++) begin
            tick;
            check("abort_no_stale", 32'(out_valid[0]), 0);
        end
        out_ready[0] = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'hA0 + 32'(n);
            tick;
        end
        in_valid[0] = 1'b0;
        tick;
        tick;
        check("restart_valid", 32'(out_valid[0]), 1);
        check("restart_d0", out_data[0], 32'hA1);
        tick;
        check("restart_d1", out_data[0], 32'hA2);
        tick;
        check("restart_end", 32'(out_valid[0]), 0);

        // all channels streaming, reset mid-stream
        for (int c = 0; c < 5; c++) cfg(c, 1'b1, 1'b0, c + 1);
        for (int c = 0; c < 5; c++) in_data[c] = 32'h100 * 32'(c) + 32'h55;
        in_valid = '1;
        for (int n = 0; n < 12; n++) tick;
        check("multi_valid", 32'(out_valid), 32'h1f);
        check("multi_data3", out_data[3], 32'h355);
        check("multi_active", 32'(ch_active), 32'h1f);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_active", 32'(ch_active), 0);
        check("mid_rst_data", 32'(|out_data), 0);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) tick;
        check("post_rst_valid", 32'(out_valid), 0);
        check("post_rst_ready", 32'(in_ready), 0);
        in_valid = '0;
        cfg(1, 1'b1, 1'b0, 2);
        check("post_rst_cfg", 32'(in_ready), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
